// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mem_arbiter_pkg                                              |
// | Purpose : Shared constants and types for the two-port memory arbiter:  |
// |           port IDs, owner-tag layout and default starvation bound.     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package mem_arbiter_pkg;

  // Port identifiers carried in the owner tag.
  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_IF  = 1'b1;

  // Owner tag field widths.
  localparam int TAG_VALID_W = 1;
  localparam int TAG_PORT_W  = 1;

  // Default number of consecutive refusals tolerated for port 1.
  localparam int DEFAULT_MAX_WAIT = 4;

  // One stage of the owner-tag pipeline.
  typedef struct packed {
    logic [TAG_VALID_W-1:0] valid;
    logic [TAG_PORT_W-1:0]  port;
  } tag_t;

endpackage : mem_arbiter_pkg
`default_nettype wire

// File: rtl/mem_arb_picker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mem_arb_picker                                               |
// | Purpose : Combinational winner selection between port 0 (priority) and |
// |           port 1, with a saturating starvation counter for port 1.     |
// | Ports   : clk, rst_n          clock, async active-low reset            |
// |           p0_req, p1_req      requests                                 |
// |           p1_flush            fetch flush, masks port-1 grant          |
// |           p0_gnt, p1_gnt      one-cycle grant pulses (combinational)   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mem_arb_picker
  import mem_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic p0_req,
  input  logic p1_req,
  input  logic p1_flush,
  output logic p0_gnt,
  output logic p1_gnt
);

  localparam int              CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             p1_ok;
  logic             starved;

  assign p1_ok   = p1_req && !p1_flush;
  assign starved = (wait_cnt == CNT_MAX);

  // Port 1 overrides port 0 only once it has been refused MAX_WAIT times.
  // Both grants are forced low while reset is asserted.
  assign p1_gnt = rst_n && p1_ok && (starved || !p0_req);
  assign p0_gnt = rst_n && p0_req && !(p1_ok && starved);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!p1_req || p1_flush || p1_gnt) begin
      wait_cnt <= '0;
    end else if (!starved) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

endmodule : mem_arb_picker
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mem_arbiter                                                  |
// | Purpose : Shares a single-ported memory between the load/store unit    |
// |           (port 0) and instruction fetch (port 1). Registers the       |
// |           winning command, tags it with its owner and routes the       |
// |           one-cycle-later response back to that owner.                 |
// | Ports   : clk, rst_n                 clock, async active-low reset     |
// |           pX_req/we/addr/wdata       requester commands                |
// |           pX_gnt                     accept pulse (combinational)      |
// |           pX_rvalid/rdata            response to requester             |
// |           p1_flush                   drop in-flight port-1 responses   |
// |           mem_request/we/addr/wdata  registered memory command         |
// |           mem_valid/rdata            memory response                   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_gnt,
  output logic                  p0_rvalid,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_gnt,
  output logic                  p1_rvalid,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  input  logic                  p1_flush,
  output logic                  mem_request,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  tag_t tag_a;  // owner of the command currently on mem_*
  tag_t tag_b;  // owner of the response currently on mem_valid
  logic any_gnt;

  mem_arb_picker #(
    .MAX_WAIT (MAX_WAIT)
  ) u_picker (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_req   (p0_req),
    .p1_req   (p1_req),
    .p1_flush (p1_flush),
    .p0_gnt   (p0_gnt),
    .p1_gnt   (p1_gnt)
  );

  assign any_gnt = p0_gnt || p1_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_request <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      tag_a       <= '0;
      tag_b       <= '0;
    end else begin
      mem_request <= any_gnt;
      // Command fields hold their last value when nobody wins.
      if (p1_gnt) begin
        mem_we    <= p1_we;
        mem_addr  <= p1_addr;
        mem_wdata <= p1_wdata;
      end else if (p0_gnt) begin
        mem_we    <= p0_we;
        mem_addr  <= p0_addr;
        mem_wdata <= p0_wdata;
      end
      // A flushed port-1 grant never reaches stage A because the picker
      // already masks p1_gnt; the stage-A port-1 tag is invalidated on its
      // way into stage B. Stage B's own port-1 tag is suppressed at the
      // output and then overwritten, which has the same effect.
      tag_a.valid <= any_gnt;
      tag_a.port  <= p1_gnt ? PORT_IF : PORT_LSU;
      tag_b.valid <= tag_a.valid && !(p1_flush && (tag_a.port == PORT_IF));
      tag_b.port  <= tag_a.port;
    end
  end

  // Responses without a valid owner tag are ignored; a valid tag with no
  // mem_valid simply retires.
  assign p0_rvalid = rst_n && tag_b.valid[0] && (tag_b.port == PORT_LSU) && mem_valid;
  assign p1_rvalid = rst_n && tag_b.valid[0] && (tag_b.port == PORT_IF) && mem_valid
                     && !p1_flush;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

endmodule : mem_arbiter
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mem_arbiter                                               |
// | Purpose : Directed self-checking bench for mem_arbiter with a simple   |
// |           one-cycle-latency memory model.                              |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          p1_flush = 1'b0;
  logic          mem_request, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  // Memory model: responds one cycle after each request.
  logic [DW-1:0] mem [0:255];
  logic          mv = 1'b0;
  logic          inject = 1'b0;
  logic [DW-1:0] rd = '0;

  always @(posedge clk) begin
    mv <= mem_request;
    if (mem_request) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        rd <= mem[mem_addr[7:0]];
    end
  end

  assign mem_valid = mv | inject;
  assign mem_rdata = rd;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MAX_WAIT   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p0_req      (p0_req),
    .p0_we       (p0_we),
    .p0_addr     (p0_addr),
    .p0_wdata    (p0_wdata),
    .p0_gnt      (p0_gnt),
    .p0_rvalid   (p0_rvalid),
    .p0_rdata    (p0_rdata),
    .p1_req      (p1_req),
    .p1_we       (p1_we),
    .p1_addr     (p1_addr),
    .p1_wdata    (p1_wdata),
    .p1_gnt      (p1_gnt),
    .p1_rvalid   (p1_rvalid),
    .p1_rdata    (p1_rdata),
    .p1_flush    (p1_flush),
    .mem_request (mem_request),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_valid   (mem_valid),
    .mem_rdata   (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let freshly driven inputs settle before sampling combinational outputs.
  task automatic settle();
    #1;
  endtask

  int exp_port [0:15];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'hDEADBEEF;
    mem[8'h20] = 32'h000000A0;
    mem[8'h30] = 32'h000000B0;
    mem[8'h31] = 32'h000000B1;

    // ---------------- reset state (requests asserted to test gating)
    p0_req = 1'b1;
    p1_req = 1'b1;
    repeat (2) cyc();
    settle();
    check("rst_mem_request", mem_request, 0);
    check("rst_mem_we",      mem_we, 0);
    check("rst_mem_addr",    mem_addr, 0);
    check("rst_mem_wdata",   mem_wdata, 0);
    check("rst_p0_gnt",      p0_gnt, 0);
    check("rst_p1_gnt",      p1_gnt, 0);
    check("rst_p0_rvalid",   p0_rvalid, 0);
    check("rst_p1_rvalid",   p1_rvalid, 0);
    p0_req = 1'b0;
    p1_req = 1'b0;
    rst_n  = 1'b1;
    repeat (2) cyc();

    // ---------------- single port-0 read of 0x10
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h10;
    settle();
    check("t1_p0_gnt", p0_gnt, 1);
    check("t1_p1_gnt", p1_gnt, 0);
    cyc();
    p0_req = 1'b0;
    settle();
    check("t1_mem_request", mem_request, 1);
    check("t1_mem_addr",    mem_addr, 32'h10);
    check("t1_mem_we",      mem_we, 0);
    check("t1_p0_rvalid_early", p0_rvalid, 0);
    cyc();
    settle();
    check("t1_p0_rvalid", p0_rvalid, 1);
    check("t1_p0_rdata",  p0_rdata, 32'hDEADBEEF);
    check("t1_p1_rvalid", p1_rvalid, 0);
    cyc();
    settle();
    check("t1_p0_rvalid_after", p0_rvalid, 0);
    check("t1_mem_request_idle", mem_request, 0);

    // ---------------- both ports continuous: p0 x4 then p1, repeating
    for (int i = 0; i < 16; i++) exp_port[i] = -1;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cyc();
      p0_req = (i < 10); p0_we = 1'b0; p0_addr = 32'h20;
      p1_req = (i < 10); p1_we = 1'b0; p1_addr = 32'h30;
      settle();
      if (i < 10) begin
        exp_port[i] = ((i % 5) == 4) ? 1 : 0;
        check($sformatf("t2_p0_gnt_%0d", i), p0_gnt, (exp_port[i] == 0));
        check($sformatf("t2_p1_gnt_%0d", i), p1_gnt, (exp_port[i] == 1));
      end
      if (i >= 2) begin
        check($sformatf("t2_p0_rvalid_%0d", i), p0_rvalid, (exp_port[i-2] == 0));
        check($sformatf("t2_p1_rvalid_%0d", i), p1_rvalid, (exp_port[i-2] == 1));
        if (exp_port[i-2] == 0) check($sformatf("t2_p0_rdata_%0d", i), p0_rdata, 32'hA0);
        if (exp_port[i-2] == 1) check($sformatf("t2_p1_rdata_%0d", i), p1_rdata, 32'hB0);
      end
    end
    cyc();

    // ---------------- port-1 reads then flush; concurrent port-0 write
    p1_req = 1'b1; p1_addr = 32'h30;
    settle();
    check("t3_p1_gnt_a", p1_gnt, 1);
    cyc();
    p1_addr = 32'h31;
    settle();
    check("t3_p1_gnt_b", p1_gnt, 1);
    cyc();
    p1_flush = 1'b1;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h40; p0_wdata = 32'h77;
    settle();
    check("t3_p1_rvalid_flush_same", p1_rvalid, 0);
    check("t3_p1_gnt_masked",        p1_gnt, 0);
    check("t3_p0_gnt_write",         p0_gnt, 1);
    cyc();
    p1_flush = 1'b0; p1_req = 1'b0; p0_req = 1'b0; p0_we = 1'b0;
    settle();
    check("t3_p1_rvalid_dropped", p1_rvalid, 0);
    cyc();
    p1_req = 1'b1; p1_flush = 1'b1;
    settle();
    check("t3_p0_write_ack", p0_rvalid, 1);
    check("t3_p1_rvalid_none", p1_rvalid, 0);
    check("t3_flush_masks_lone_p1", p1_gnt, 0);
    cyc();
    p1_req = 1'b0; p1_flush = 1'b0;
    cyc();

    // ---------------- port-0 write 0x55 @4, then port-1 read of 4
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h4; p0_wdata = 32'h55;
    settle();
    check("t4_p0_gnt", p0_gnt, 1);
    cyc();
    p0_req = 1'b0; p0_we = 1'b0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h4;
    settle();
    check("t4_p1_gnt", p1_gnt, 1);
    cyc();
    p1_req = 1'b0;
    settle();
    check("t4_p0_ack", p0_rvalid, 1);
    cyc();
    settle();
    check("t4_p1_rvalid", p1_rvalid, 1);
    check("t4_p1_rdata",  p1_rdata, 32'h55);
    cyc();

    // ---------------- reset with two transactions in flight
    p0_req = 1'b1; p0_addr = 32'h10;
    cyc();
    p0_req = 1'b0;
    p1_req = 1'b1; p1_addr = 32'h30;
    cyc();
    p1_req = 1'b0;
    settle();
    rst_n = 1'b0;
    #1;
    check("t5_mem_request_async", mem_request, 0);
    check("t5_mem_addr_async",    mem_addr, 0);
    check("t5_p0_rvalid_in_rst",  p0_rvalid, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("t5_p0_rvalid_post_%0d", i), p0_rvalid, 0);
      check($sformatf("t5_p1_rvalid_post_%0d", i), p1_rvalid, 0);
      cyc();
    end

    // ---------------- mem_valid injected with no tag valid
    inject = 1'b1;
    settle();
    check("t6_p0_rvalid", p0_rvalid, 0);
    check("t6_p1_rvalid", p1_rvalid, 0);
    cyc();
    inject = 1'b0;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_mem_arbiter
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-ported `memory_interface` between the load/store unit (port 0) and instruction fetch (port 1). It registers the winning command onto the memory request bus and tags each in-flight transaction with its owner. It routes the memory's one-cycle-later `valid`/`data_o` back to the correct requester. Port 0 has fixed priority, bounded by a starvation guard for port 1; port 1 supports a fetch flush that discards its in-flight responses.

## Interface
- `DATA_WIDTH`, 32, memory word width
- `ADDR_WIDTH`, 32, memory address width
- `MAX_WAIT`, 4, consecutive cycles port 1 may be refused before it overrides port 0 (≥1)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `p0_req` / `p1_req`  in  1  request; command fields held stable until granted
- `p0_we` / `p1_we`  in  1  1 = write, 0 = read
- `p0_addr` / `p1_addr`  in  ADDR_WIDTH  word address
- `p0_wdata` / `p1_wdata`  in  DATA_WIDTH  write data
- `p0_gnt` / `p1_gnt`  out  1  combinational, one-cycle accept pulse
- `p0_rvalid` / `p1_rvalid`  out  1  response pulse for reads and writes
- `p0_rdata` / `p1_rdata`  out  DATA_WIDTH  read data, meaningful only with rvalid
- `p1_flush`  in  1  discard all in-flight port-1 transactions
- `mem_request`  out  1  registered request to memory
- `mem_we`  out  1  registered write enable
- `mem_addr`  out  ADDR_WIDTH  registered address
- `mem_wdata`  out  DATA_WIDTH  registered write data
- `mem_valid`  in  1  memory response, one cycle after `mem_request`
- `mem_rdata`  in  DATA_WIDTH  memory read data

## Operation
- Arbitration, combinational each cycle:
  - If `p1_req` is high, `p1_flush` is low, and `wait_cnt == MAX_WAIT`: port 1 wins.
  - Otherwise, if `p0_req` is high: port 0 wins.
  - Otherwise, if `p1_req` is high and `p1_flush` is low: port 1 wins.
- `p1_flush` masks `p1_gnt` in the same cycle.
- Winner's `gnt` is high for that cycle only. Its command is registered into `mem_*` and `mem_request` is set.
- With no winner, `mem_request` registers 0. `mem_we`, `mem_addr` and `mem_wdata` hold their previous values.
- One grant is possible per cycle: back-to-back transactions are legal and sustained throughput is 1/cycle.
- Starvation counter `wait_cnt`, width clog2(MAX_WAIT+1):
  - Increments when `p1_req && !p1_gnt && !p1_flush`.
  - Clears on `p1_gnt`, on `!p1_req`, or on `p1_flush`.
  - Saturates at MAX_WAIT.
- Owner tag pipeline, two stages, each holding {valid, port}:
  - Stage A is loaded with the grant of cycle N and corresponds to `mem_request` at N+1.
  - Stage B is loaded from stage A and corresponds to `mem_valid` at N+2.
- Response routing:
  - `pX_rvalid = B.valid && B.port==X && mem_valid && !(X==1 && p1_flush)`.
  - `pX_rdata = mem_rdata`, passed through combinationally.
- `p1_flush` clears the valid bit of every port-1 tag in stages A and B. Those transactions still complete at the memory; their responses are dropped, and writes still take effect.
- `mem_valid` with `B.valid == 0` is ignored.
- Tag valid with `mem_valid == 0` produces no response and no error; the tag retires normally.

## Timing
- Reset values:
  - `mem_request`, `mem_we`: 0
  - `mem_addr`, `mem_wdata`: 0
  - both tag stages invalid; `wait_cnt`: 0
  - `gnt` and `rvalid` are low whenever reset is asserted
- Reset during operation aborts all in-flight transactions: no rvalid fires for them after reset is released.
- Latency: grant at cycle N, `mem_request` at N+1, `pX_rvalid`/`pX_rdata` at N+2.
- Simultaneous requests: port 0 wins unless the counter has saturated. After port 1 has been refused MAX_WAIT times, port 1 is granted on the next cycle.
- A flush in the same cycle as a port-1 rvalid suppresses that rvalid.
- A port-0 rvalid is never affected by flush.

## Structure
- Shared package/header holds:
  - port ID constants `PORT_LSU=0`, `PORT_IF=1`
  - tag field widths
  - default `MAX_WAIT`
- Natural sub-module: `mem_arb_picker`, containing the combinational winner selection and `wait_cnt`. The tag pipeline and command registers stay in `mem_arbiter`.

## Test plan
- Single port-0 read of addr 0x10 (memory holds 0xDEADBEEF): `p0_gnt` at N, `mem_request` at N+1, `p0_rvalid` with 0xDEADBEEF at N+2, port 1 silent.
- Both ports request continuously, MAX_WAIT=4: grant pattern is p0,p0,p0,p0,p1 repeating, and every response is routed to the correct port.
- Port-1 reads granted on two consecutive cycles, then `p1_flush` the following cycle: neither `p1_rvalid` fires, and a concurrent port-0 write is acked normally.
- Port-0 write of 0x55 to addr 0x4, then a port-1 read of 0x4 on the next cycle: port 1 receives 0x55 at its N+2.
- `rst_n` deasserted with two transactions in flight: all `mem_*` outputs go to 0 asynchronously, and no rvalid appears after reset is released.
- `mem_valid` injected with no tag valid: no rvalid on either port.
